// File: rtl/fifo_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_pkg
// Description : Shared types and default sizing for the synchronous FWFT FIFO.
//               fifo_op_e names the combination of effective read/write
//               happening at a clock edge: {write, read}.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_sync_pkg;

  localparam int DEFAULT_BIT_WIDTH  = 16;
  localparam int DEFAULT_FIFO_DEPTH = 8;

  // Bit 1 = effective write, bit 0 = effective read.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage : fifo_sync_pkg
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync
// Description : Single-clock first-word-fall-through FIFO with registered
//               empty/full flags and combinational look-ahead (_next) flags.
// Ports       : clk             - system clock, rising edge
//               rst             - asynchronous active-high reset
//               read_en         - pop head entry at this edge
//               read_data       - current head entry (no read latency)
//               write_en        - push write_data at this edge
//               write_data      - data to push
//               fifo_empty      - registered empty flag
//               fifo_full       - registered full flag
//               fifo_empty_next - value fifo_empty takes after this edge
//               fifo_full_next  - value fifo_full takes after this edge
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int BIT_WIDTH  = DEFAULT_BIT_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_en,
  output logic [BIT_WIDTH-1:0] read_data,
  input  logic                 write_en,
  input  logic [BIT_WIDTH-1:0] write_data,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 fifo_empty_next,
  output logic                 fifo_full_next
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;   // MSB is the wrap bit

  logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr_next;
  logic [PTR_W-1:0]     wr_ptr_next;
  logic                 do_read;
  logic                 do_write;
  fifo_op_e             op;

  // A write at full is accepted only when a read frees a slot in the same
  // edge; full implies non-empty, so that read is always effective.
  assign do_read  = read_en & ~fifo_empty;
  assign do_write = write_en & (~fifo_full | read_en);
  assign op       = fifo_op_e'({do_write, do_read});

  always_comb begin
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    case (op)
      OP_READ:  rd_ptr_next = rd_ptr + PTR_W'(1);
      OP_WRITE: wr_ptr_next = wr_ptr + PTR_W'(1);
      OP_BOTH: begin
        rd_ptr_next = rd_ptr + PTR_W'(1);
        wr_ptr_next = wr_ptr + PTR_W'(1);
      end
      default: ;
    endcase
  end

  // Equal pointers = empty; same index but opposite wrap bit = full.
  assign fifo_empty_next = (rd_ptr_next == wr_ptr_next);
  assign fifo_full_next  = (rd_ptr_next[ADDR_W-1:0] == wr_ptr_next[ADDR_W-1:0]) &&
                           (rd_ptr_next[ADDR_W] != wr_ptr_next[ADDR_W]);

  assign read_data = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_next;
      wr_ptr     <= wr_ptr_next;
      fifo_empty <= fifo_empty_next;
      fifo_full  <= fifo_full_next;
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[wr_ptr[ADDR_W-1:0]] <= write_data;
    end
  end

endmodule : fifo_sync
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync
// Description : Self-checking bench for fifo_sync (BIT_WIDTH=16, DEPTH=8).
//               Directed table of vectors, hand-written reset/wrap sequences
//               and random traffic checked against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync;

  localparam int BW    = 16;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          read_en;
  logic [BW-1:0] read_data;
  logic          write_en;
  logic [BW-1:0] write_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_empty_next;
  logic          fifo_full_next;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] model[$];

  fifo_sync #(.BIT_WIDTH(BW), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .read_en         (read_en),
    .read_data       (read_data),
    .write_en        (write_en),
    .write_data      (write_data),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .fifo_empty_next (fifo_empty_next),
    .fifo_full_next  (fifo_full_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [BW-1:0] wd;
    logic          re;
    logic          exp_empty_next;
    logic          exp_full_next;
    logic          exp_empty;
    logic          exp_full;
    logic          chk_data;
    logic [BW-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic we, input logic [BW-1:0] wd, input logic re,
                         input logic en, input logic fn, input logic e, input logic f,
                         input logic cd, input logic [BW-1:0] d);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re;
    v.exp_empty_next = en; v.exp_full_next = fn;
    v.exp_empty = e; v.exp_full = f; v.chk_data = cd; v.exp_data = d;
    vecs.push_back(v);
  endtask

  // One clock cycle against the queue model. Called at a negedge.
  task automatic step(input logic we, input logic [BW-1:0] wd, input logic re);
    int  sz;
    int  szn;
    bit  er;
    bit  ew;
    write_en = we; write_data = wd; read_en = re;
    #1;
    sz  = model.size();
    er  = re && (sz > 0);
    ew  = we && ((sz < DEPTH) || re);
    szn = sz - int'(er) + int'(ew);
    check("empty_next", 32'(fifo_empty_next), 32'(szn == 0));
    check("full_next",  32'(fifo_full_next),  32'(szn == DEPTH));
    @(posedge clk);
    if (er) void'(model.pop_front());
    if (ew) model.push_back(wd);
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0;
    check("empty", 32'(fifo_empty), 32'(model.size() == 0));
    check("full",  32'(fifo_full),  32'(model.size() == DEPTH));
    check("not_both", 32'(fifo_empty & fifo_full), 32'd0);
    if (model.size() > 0) check("read_data", 32'(read_data), 32'(model[0]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_empty",      32'(fifo_empty),      32'd1);
    check("rst_full",       32'(fifo_full),       32'd0);
    check("rst_read_data",  32'(read_data),       32'd0);
    check("rst_empty_next", 32'(fifo_empty_next), 32'd1);
    check("rst_full_next",  32'(fifo_full_next),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    model.delete();
  endtask

  initial begin
    rst = 1'b1; read_en = 1'b0; write_en = 1'b0; write_data = '0;

    // Directed table: fill, drop at full, read+write at full, drain,
    // read at empty, read+write at empty, fall-through.
    for (int k = 1; k <= 8; k++)
      add_vec(1'b1, BW'(k), 1'b0, 1'b0, (k == 8), 1'b0, (k == 8), 1'b1, 16'h0001);
    add_vec(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001);
    add_vec(1'b1, 16'h7777, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002);
    for (int k = 1; k <= 6; k++)
      add_vec(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BW'(k + 2));
    add_vec(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777);
    add_vec(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    add_vec(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    add_vec(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    add_vec(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    add_vec(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD);
    add_vec(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD);

    do_reset();

    foreach (vecs[i]) begin
      write_en = vecs[i].we; write_data = vecs[i].wd; read_en = vecs[i].re;
      #1;
      check($sformatf("vec%0d_empty_next", i), 32'(fifo_empty_next), 32'(vecs[i].exp_empty_next));
      check($sformatf("vec%0d_full_next", i),  32'(fifo_full_next),  32'(vecs[i].exp_full_next));
      @(posedge clk);
      @(negedge clk);
      write_en = 1'b0; read_en = 1'b0;
      check($sformatf("vec%0d_empty", i), 32'(fifo_empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_full", i),  32'(fifo_full),  32'(vecs[i].exp_full));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_read_data", i), 32'(read_data), 32'(vecs[i].exp_data));
    end

    // Wrap test: occupancy 3, 20 simultaneous push/pop cycles crossing
    // the index rollover several times.
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, BW'(16'h0100 + k), 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, BW'(16'h0200 + k), 1'b1);
    while (model.size() > 0) step(1'b0, '0, 1'b1);

    // Random traffic against the model, biased to reach both full and empty.
    for (int k = 0; k < 400; k++) begin
      logic we;
      logic re;
      if (k < 200) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) == 0);
      end else begin
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 3) != 0);
      end
      if (k == 200 || k == 320) begin
        we = $urandom_range(0, 1) == 1;
        re = $urandom_range(0, 1) == 1;
      end
      step(we, BW'($urandom), re);
    end

    // Reset mid-operation discards contents; first cycle after is fresh.
    for (int k = 0; k < 5; k++) step(1'b1, BW'($urandom), 1'b0);
    do_reset();
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_fifo_sync
`default_nettype wire

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16: data word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: number of entries; power of 2, >= 2.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1, system clock, all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 read_en  input  1  pop the head entry at this clock edge.
REQ-006 read_data  output  BIT_WIDTH  current head entry, first-word-fall-through.
REQ-007 write_en  input  1  push write_data at this clock edge.
REQ-008 write_data  input  BIT_WIDTH  data to push.
REQ-009 fifo_empty  output  1  registered empty flag.
REQ-010 fifo_full  output  1  registered full flag.
REQ-011 fifo_empty_next  output  1  combinational; value fifo_empty takes after this edge.
REQ-012 fifo_full_next  output  1  combinational; value fifo_full takes after this edge.

Function
REQ-013 SHALL keep storage of FIFO_DEPTH x BIT_WIDTH, plus read and write pointers of log2(FIFO_DEPTH)+1 bits (MSB = wrap bit).
REQ-014 read_data SHALL equal mem[rd_ptr index] combinationally, with no read latency; it is valid whenever fifo_empty=0 and undefined in content (but stable) when empty.
REQ-015 Effective write SHALL be write_en & (~fifo_full | read_en); an effective write stores write_data at wr_ptr and increments wr_ptr by 1, modulo 2*FIFO_DEPTH.
REQ-016 Effective read SHALL be read_en & ~fifo_empty; an effective read increments rd_ptr by 1, modulo 2*FIFO_DEPTH.
REQ-017 A read on an empty FIFO SHALL be ignored; only the write takes effect if one is present.
REQ-018 A write on a full FIFO without read_en SHALL be dropped; pointers and data are unchanged.
REQ-019 Simultaneous effective read and write SHALL leave occupancy unchanged, including at full.
REQ-020 fifo_empty_next SHALL be 1 iff the next-state pointers are equal, including the wrap bit.
REQ-021 fifo_full_next SHALL be 1 iff the next-state pointers differ only in the wrap bit.
REQ-022 Both _next flags SHALL be computed from the current read_en and write_en in the same cycle.
REQ-023 fifo_empty and fifo_full SHALL be registered copies of the _next flags.
REQ-024 fifo_empty and fifo_full SHALL never both be 1.
REQ-025 Pointer wrap-around SHALL be seamless; there is no lost or duplicated entry at the index rollover.

Reset
REQ-026 On rst=1, asynchronously: rd_ptr=0, wr_ptr=0, fifo_empty=1, fifo_full=0, and all memory words are 0, so read_data=0.
REQ-027 Reset asserted mid-operation SHALL discard all contents immediately; the first edge after release behaves as a fresh FIFO.

Structure
REQ-028 SHALL be a single self-contained module with no sub-modules.
REQ-029 Pointer width SHALL derive locally via $clog2(FIFO_DEPTH).
REQ-030 No shared package is required; BIT_WIDTH and FIFO_DEPTH are supplied by the instantiating block, e.g. from the PE header constants.
REQ-031 Implementation SHALL be register-based storage, synthesizable, with no latches.

Verification
REQ-032 Reset check: assert rst -> fifo_empty=1, fifo_full=0, read_data=0, fifo_empty_next=1, fifo_full_next=0.
REQ-033 Fill/drain, DEPTH=8: write 0x0001..0x0008 on consecutive cycles -> fifo_full_next=1 during the 8th write and fifo_full=1 after it. Then read 8 times -> read_data shows 1..8 in order, fifo_empty_next=1 during the 8th read.
REQ-034 First-word-fall-through: from empty, write 0xABCD -> the next cycle gives fifo_empty=0 and read_data=0xABCD with no read_en.
REQ-035 Boundary drops: when full, write 0x5555 alone -> no change and the head is unchanged. When empty, read_en alone -> pointers unchanged, fifo_empty stays 1.
REQ-036 Simultaneous access: at full, read and write 0x7777 together -> fifo_full stays 1, head advances, 0x7777 is later read last. At empty, read and write 0x1234 together -> fifo_empty=0, read_data=0x1234.
REQ-037 Wrap test: 20 interleaved push/pop cycles at occupancy 3 -> output sequence equals input sequence, with no full or empty glitch.
